uno_ctrl: RTL
=============

UNO_CTRL -- requirements
Module: uno_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 12, operand width matching the uno datapath.
REQ-002 SHALL have parameter TERMS, default 4, range 2..8, polynomial coefficient count per non-MAC op.
REQ-003 SHALL have parameter MAC_LAT, default 1, cycles from uno input to valid uno result.
REQ-004 SHALL have ports (name direction width meaning), one clock, reset asynchronous active-high:
  clk  in  1  clock;
  rst  in  1  async active-high reset;
  req_valid  in  1  request present;
  req_ready  out  1  request accepted when high with req_valid;
  req_op  in  2  00 MAC, 01 div, 10 exp, 11 log;
  req_x  in  DATA_W  operand X;
  req_y  in  DATA_W  operand Y;
  req_z  in  2*DATA_W  MAC addend;
  req_acc  in  1  MAC mode: accumulate onto previous result instead of req_z;
  coef_wr_en  in  1  coefficient write strobe;
  coef_wr_op  in  2  table select (01/10/11; 00 ignored);
  coef_wr_addr  in  3  term index;
  coef_wr_data  in  DATA_W  coefficient;
  uno_op  out  2  op to uno;
  uno_x, uno_y  out  DATA_W  operands to uno;
  uno_z  out  2*DATA_W  addend to uno;
  uno_coeff  out  DATA_W  coefficient to uno;
  uno_first, uno_last, uno_acc_en  out  1  sequencing strobes to uno;
  uno_out  in  2*DATA_W+4  uno result;
  res_valid  out  1  result held;
  res_ready  in  1  result consumed;
  res_data  out  2*DATA_W+4  captured result;
  done_cnt  out  32  completed-op counter.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, DRAIN, HOLD; req_ready high only in IDLE.
REQ-006 IDLE: on req_valid, capture op/x/y/z/acc, clear term counter k, go ISSUE.
REQ-007 ISSUE, op 00: one cycle; uno_op=00, uno_x/uno_y/uno_z = captured values, uno_acc_en=captured acc; uno_first=uno_last=0; go DRAIN.
REQ-008 ISSUE, op != 00: exactly TERMS cycles, k=0..TERMS-1; uno_coeff=table[op][k]; uno_first=1 only at k=0; uno_last=1 only at k=TERMS-1; uno_x/uno_y held constant; go DRAIN after k=TERMS-1.
REQ-009 Outside ISSUE, all uno_* outputs SHALL be 0 (uno_op retains last issued op).
REQ-010 DRAIN: wait MAC_LAT cycles after last issue cycle, capture uno_out into res_data, assert res_valid, go HOLD.
REQ-011 HOLD: res_valid=1, res_data stable; on res_ready go IDLE; no new request accepted in the same cycle.
REQ-012 Coefficient table: 3 x TERMS x DATA_W registers; write when coef_wr_en, coef_wr_op!=00, coef_wr_addr<TERMS; other writes ignored.
REQ-013 Write and ISSUE read of the same entry in one cycle: read returns old value, new value visible next cycle.
REQ-014 Writes SHALL be accepted in every FSM state.
REQ-015 req_acc SHALL be ignored for op != 00.
REQ-016 Latency: req accept to res_valid = 1 + issue cycles + MAC_LAT (op 00: 2+MAC_LAT; others: 1+TERMS+MAC_LAT).

Reset
REQ-017 rst SHALL asynchronously force IDLE, k=0, res_valid=0, res_data=0, all uno_* outputs 0, table entries 0, done_cnt 0.
REQ-018 rst mid-ISSUE/DRAIN/HOLD SHALL abort the operation; no result produced after release.

Configuration
REQ-019 Macro UNO_CTRL_PERF_CNT_EN: when defined, done_cnt increments by 1 on each HOLD->IDLE transition, wrapping 2^32-1 to 0.
REQ-020 Without UNO_CTRL_PERF_CNT_EN, done_cnt SHALL be tied 0 and no counter logic exists.

Verification
REQ-021 Reset mid-exp issue (k=2) -> next cycle FSM IDLE, req_ready=1, res_valid=0, uno_first/uno_last=0.
REQ-022 Load table[10]={1,2,3,4}, exp req x=0x180 -> uno_coeff 1,2,3,4 on 4 consecutive cycles, uno_first on cycle 1, uno_last on cycle 4; res_valid 6 cycles after accept (TERMS=4, MAC_LAT=1).
REQ-023 MAC req x=3, y=5, z=7, acc=0 -> one issue cycle with uno_acc_en=0; res_data = uno_out sampled 1 cycle later; second req acc=1 -> uno_acc_en=1.
REQ-024 res_ready held 0 for 10 cycles -> res_valid and res_data stable, req_ready=0 throughout; res_ready=1 -> IDLE next cycle.
REQ-025 Write table[11][0]=0xABC in same cycle log issue reads k=0 -> issued coeff is old value; next log op issues 0xABC at k=0.
REQ-026 With UNO_CTRL_PERF_CNT_EN, 3 completed ops -> done_cnt=3; preload 0xFFFFFFFF then one op -> 0; without macro done_cnt=0.

Source files
------------

// File: rtl/uno_ctrl.sv
// uno_ctrl: request sequencer for the uno MAC/polynomial datapath with per-op coefficient tables.
// Optional completed-op counter on done_cnt is built when UNO_CTRL_PERF_CNT_EN is defined.
module uno_ctrl #(
   parameter int unsigned DATA_W  = 12,
   parameter int unsigned TERMS   = 4,
   parameter int unsigned MAC_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [DATA_W-1:0]     req_x,
   input  logic [DATA_W-1:0]     req_y,
   input  logic [2*DATA_W-1:0]   req_z,
   input  logic                  req_acc,
   input  logic                  coef_wr_en,
   input  logic [1:0]            coef_wr_op,
   input  logic [2:0]            coef_wr_addr,
   input  logic [DATA_W-1:0]     coef_wr_data,
   output logic [1:0]            uno_op,
   output logic [DATA_W-1:0]     uno_x,
   output logic [DATA_W-1:0]     uno_y,
   output logic [2*DATA_W-1:0]   uno_z,
   output logic [DATA_W-1:0]     uno_coeff,
   output logic                  uno_first,
   output logic                  uno_last,
   output logic                  uno_acc_en,
   input  logic [2*DATA_W+3:0]   uno_out,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [2*DATA_W+3:0]   res_data,
   output logic [31:0]           done_cnt
);

   localparam int unsigned K_W   = (TERMS > 1) ? $clog2(TERMS) : 1;
   localparam int unsigned LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam int unsigned Z_W   = 2 * DATA_W;
   localparam int unsigned RES_W = 2 * DATA_W + 4;
   localparam logic [1:0]  OP_MAC = 2'b00;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

   typedef struct packed {
      logic [1:0]        op;
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] y;
      logic [Z_W-1:0]    z;
      logic              acc;
   } req_t;

   state_t             state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   req_t               req_q;
   logic               res_valid_q;
   logic [RES_W-1:0]   res_data_q;
   logic               accept, capture, consume, last_term, wr_ok;

   // Tables for div/exp/log, indexed by op-1
   logic [DATA_W-1:0]  tbl [3][TERMS];

   assign last_term = (k_q == K_W'(TERMS - 1));
   assign wr_ok     = coef_wr_en && (coef_wr_op != OP_MAC) && ({1'b0, coef_wr_addr} < 4'(TERMS));
   assign uno_op    = req_q.op;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         lat_q   <= lat_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      k_d        = '0;
      lat_d      = '0;
      accept     = 1'b0;
      capture    = 1'b0;
      consume    = 1'b0;
      req_ready  = 1'b0;
      uno_x      = '0;
      uno_y      = '0;
      uno_z      = '0;
      uno_coeff  = '0;
      uno_first  = 1'b0;
      uno_last   = 1'b0;
      uno_acc_en = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            uno_x = req_q.x;
            uno_y = req_q.y;
            if (req_q.op == OP_MAC) begin
               uno_z      = req_q.z;
               uno_acc_en = req_q.acc;
               state_d    = DRAIN;
            end else begin
               uno_coeff = tbl[2'(req_q.op - 2'd1)][k_q];
               uno_first = (k_q == '0);
               uno_last  = last_term;
               if (last_term) state_d = DRAIN;
               else           k_d     = k_q + K_W'(1);
            end
         end
         DRAIN: begin
            // uno_out reflects the last issue after MAC_LAT cycles
            if (lat_q == LAT_W'(MAC_LAT - 1)) begin
               capture = 1'b1;
               state_d = HOLD;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         HOLD: begin
            if (res_ready) begin
               consume = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture; acc only meaningful for MAC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q <= '0;
      end else if (accept) begin
         req_q.op  <= req_op;
         req_q.x   <= req_x;
         req_q.y   <= req_y;
         req_q.z   <= req_z;
         req_q.acc <= req_acc && (req_op == OP_MAC);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else if (capture) begin
         res_valid_q <= 1'b1;
         res_data_q  <= uno_out;
      end else if (consume) begin
         res_valid_q <= 1'b0;
      end
   end

   // Writes land at the edge, so a same-cycle ISSUE read sees the old entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl <= '{default: '0};
      end else if (wr_ok) begin
         tbl[2'(coef_wr_op - 2'd1)][K_W'(coef_wr_addr)] <= coef_wr_data;
      end
   end

`ifdef UNO_CTRL_PERF_CNT_EN
   logic [31:0] done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          done_q <= '0;
      else if (consume) done_q <= done_q + 32'd1;
   end

   assign done_cnt = done_q;
`else
   assign done_cnt = '0;
`endif

endmodule
